uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 10416, clk cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 Port: clk  input  1  system clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req0  input  1  requester 0 has a byte pending.
REQ-005 Port: data0  input  8  requester 0 byte; stable while req0 high.
REQ-006 Port: ack0  output  1  one-cycle pulse: data0 latched, frame started.
REQ-007 Port: req1  input  1  requester 1 has a byte pending.
REQ-008 Port: data1  input  8  requester 1 byte; stable while req1 high.
REQ-009 Port: ack1  output  1  one-cycle pulse: data1 latched, frame started.
REQ-010 Port: tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-011 Port: busy  output  1  high while a frame is on the line.
REQ-012 Port: src  output  1  requester owning the current or most recent frame.

Function
REQ-013 The block SHALL share one UART transmit line between two requesters, with round-robin arbitration and internal bit timing; no external baud tick.
REQ-014 States: IDLE, START, DATA, STOP; all outputs registered.
REQ-015 IDLE: when req0 or req1 is high at a posedge, the block SHALL latch the winner's byte, set src, pulse its ack for exactly the next cycle, and enter START. The same cycle shows tx=0 and busy=1.
REQ-016 Tie (both req high in IDLE): grant the requester not served last; the last-served pointer resets to 1, so req0 wins the first tie.
REQ-017 Single request: grant it regardless of the pointer; the pointer updates to the granted index on every grant.
REQ-018 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: bits 0..7 of the latched byte, LSB first, each held exactly CLKS_PER_BIT cycles; 3-bit index wraps 7->STOP.
REQ-020 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then IDLE.
REQ-021 Bit counter counts 0..CLKS_PER_BIT-1 and clears on each bit boundary and on entry to START; 16 bits wide.
REQ-022 busy=1 in START/DATA/STOP, 0 in IDLE.
REQ-023 Frame = 10*CLKS_PER_BIT cycles. IDLE lasts at least 1 cycle between frames, so back-to-back frames start every 10*CLKS_PER_BIT+1 cycles.
REQ-024 req/data changes after ack SHALL NOT affect the frame in flight. A req dropped before its grant is never acked.
REQ-025 ack0 and ack1 SHALL never be high together; each ack is high for at most one cycle per frame.
REQ-026 Requester protocol: after ack, req stays high only if a new byte is presented on data; a held req is re-arbitrated at the next IDLE.

Reset
REQ-027 rst high SHALL immediately force state IDLE, tx=1, busy=0, ack0=0, ack1=0, src=0, bit counter 0, bit index 0, last-served pointer 1.
REQ-028 Reset mid-frame SHALL abort the frame with no further ack, and tx returns high asynchronously.
REQ-029 After rst deasserts, the first grant occurs at the first posedge that sees a request.

Verification (CLKS_PER_BIT=4, frame=40 cycles)
REQ-030 Assert rst -> tx=1, busy=0, ack0=ack1=0, src=0 without waiting for a clock edge.
REQ-031 req0=1, data0=0xA5 for one grant -> ack0 pulses 1 cycle. tx = 0 | 1,0,1,0,0,1,0,1 | 1, each value 4 cycles; busy high 40 cycles; src=0.
REQ-032 req0=1 (0x11) and req1=1 (0x22) together after reset:
- 0x11 sent first;
- ack1 occurs 41 cycles after ack0;
- src=1 during the second frame.
REQ-033 req0 and req1 held high for 4 frames -> grant order 0,1,0,1; acks never overlap; 1 idle cycle between frames.
REQ-034 rst pulsed during DATA bit 3 -> tx=1 and busy=0 at once; after release with req1=1, data1=0x3C, a clean full frame follows with ack1.
REQ-035 req1 pulsed high for 1 cycle while busy, low before IDLE -> no ack1 and no second frame.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : two-requester round-robin arbiter feeding one 8N1 UART TX
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx,
  output logic       busy,
  output logic       src
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] C_BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        src_q, src_d;

  logic        w_bit_end;
  logic        w_grant;
  logic [2:0]  w_idx_nxt;

  assign w_bit_end = (cnt_q == C_BIT_LAST);
  assign w_idx_nxt = idx_q + 3'd1;
  // On a tie the requester not served last wins; a lone request always wins.
  assign w_grant   = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    last_d  = last_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    src_d   = src_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          byte_d  = w_grant ? data1 : data0;
          src_d   = w_grant;
          last_d  = w_grant;
          ack0_d  = ~w_grant;
          ack1_d  = w_grant;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          cnt_d   = 16'd0;
          tx_d    = byte_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          cnt_d = 16'd0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = w_idx_nxt;
            tx_d  = byte_q[w_idx_nxt];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      byte_q  <= 8'd0;
      last_q  <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      src_q   <= src_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign src  = src_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : randomized scoreboard bench for uart_tx_arbiter
// Revision: 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk, rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, tx, busy, src;

  typedef struct {
    bit         who;
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_last = 1'b1;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx(tx), .busy(busy), .src(src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack pops one expected frame and the whole frame is checked bit by bit.
  initial begin
    int         k = 0;
    int         cyc = 0;
    int         last_ack = -1;
    bit         in_frame = 0;
    bit         exp_idle = 0;
    bit         exp_src = 0;
    logic [7:0] b = 8'h00;
    logic       exp_tx;
    exp_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_frame = 0;
        exp_idle = 0;
        last_ack = -1;
        continue;
      end
      if (ack0 && ack1) chk("ack_overlap", 1, 0);
      if (ack0 || ack1) begin
        if (in_frame) chk("ack_in_frame", 1, 0);
        if (q.size() == 0) begin
          chk("unexpected_ack", {31'd0, ack1}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("ack_line", {31'd0, ack1}, {31'd0, e.who});
          chk("src_at_ack", {31'd0, src}, {31'd0, e.who});
          if (e.b2b) chk("b2b_gap", cyc - last_ack, FRAME + 1);
          else if (last_ack >= 0) chk("min_gap", {31'd0, (cyc - last_ack) >= FRAME + 1}, 1);
          in_frame = 1;
          k        = 0;
          b        = e.data;
          exp_src  = e.who;
        end
        last_ack = cyc;
      end
      if (in_frame) begin
        if (k < CPB)            exp_tx = 1'b0;
        else if (k >= 9 * CPB)  exp_tx = 1'b1;
        else                    exp_tx = b[(k - CPB) / CPB];
        chk("tx_bit", {31'd0, tx}, {31'd0, exp_tx});
        chk("busy_frame", {31'd0, busy}, 1);
        chk("src_frame", {31'd0, src}, {31'd0, exp_src});
        k++;
        if (k == FRAME) begin
          in_frame = 0;
          exp_idle = 1;
        end
      end else if (exp_idle) begin
        chk("busy_idle", {31'd0, busy}, 0);
        chk("tx_idle", {31'd0, tx}, 1);
        exp_idle = 0;
      end
    end
  end

  task automatic wait_ack(input bit r, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r ? ack1 : ack0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  // n0/n1 frames per requester, both requests raised together and held until exhausted.
  task automatic run_round(input int n0, input int n1, input logic [7:0] f0, input logic [7:0] f1);
    logic [7:0] b0[4];
    logic [7:0] b1[4];
    int p0 = n0, p1 = n1, i0 = 0, i1 = 0;
    int budget;
    bit g, first = 1;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      b0[i] = 8'($urandom);
      b1[i] = 8'($urandom);
    end
    b0[0] = f0;
    b1[0] = f1;
    while (p0 > 0 || p1 > 0) begin
      g = (p0 > 0 && p1 > 0) ? ~model_last : (p1 > 0);
      e.who  = g;
      e.data = g ? b1[n1 - p1] : b0[n0 - p0];
      e.b2b  = !first;
      q.push_back(e);
      if (g) p1--; else p0--;
      model_last = g;
      first = 0;
    end
    req0  = (n0 > 0);
    data0 = b0[0];
    req1  = (n1 > 0);
    data1 = b1[0];
    budget = (n0 + n1 + 1) * (FRAME + 10);
    while ((i0 < n0 || i1 < n1) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack0) begin
        i0++;
        if (i0 < n0) data0 = b0[i0];
        else begin req0 = 0; data0 = 8'($urandom); end
      end
      if (ack1) begin
        i1++;
        if (i1 < n1) data1 = b1[i1];
        else begin req1 = 0; data1 = 8'($urandom); end
      end
    end
    if (budget == 0) begin
      chk("round_timeout", 0, 1);
      req0 = 0;
      req1 = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    q.delete();
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit   ok;
    exp_t e;
    int   n0, n1;
    rst = 1; req0 = 0; req1 = 0; data0 = 8'h00; data1 = 8'h00;
    #1;
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_acks", {30'd0, ack1, ack0}, 0);
    chk("rst_src", {31'd0, src}, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    run_round(1, 0, 8'hA5, 8'h00);
    repeat (FRAME + 5) @(negedge clk);

    do_reset();
    run_round(1, 1, 8'h11, 8'h22);
    run_round(2, 2, 8'h5A, 8'hC3);
    repeat (FRAME + 5) @(negedge clk);

    // A req1 blip while busy must never be granted.
    e.who = 0; e.data = 8'h96; e.b2b = 0;
    q.push_back(e);
    model_last = 0;
    req0 = 1; data0 = 8'h96;
    wait_ack(0, ok);
    req0 = 0;
    repeat (10) @(negedge clk);
    req1 = 1; data1 = 8'hEE;
    @(negedge clk);
    req1 = 0;
    repeat (2 * FRAME) @(negedge clk);
    chk("blip_queue_empty", q.size(), 0);

    // Abort a req1 frame during data bit 3, then a clean frame from req1.
    e.who = 1; e.data = 8'hF0; e.b2b = 0;
    q.push_back(e);
    model_last = 1;
    req1 = 1; data1 = 8'hF0;
    wait_ack(1, ok);
    req1 = 0;
    repeat (CPB + 3 * CPB + 2) @(negedge clk);
    chk("pre_abort_busy", {31'd0, busy}, 1);
    #3;
    rst = 1;
    q.delete();
    model_last = 1'b1;
    #1;
    chk("abort_tx", {31'd0, tx}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_acks", {30'd0, ack1, ack0}, 0);
    chk("abort_src", {31'd0, src}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    run_round(0, 1, 8'h00, 8'h3C);

    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 45)) @(negedge clk);
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n0 = 1;
      run_round(n0, n1, 8'($urandom), 8'($urandom));
    end
    repeat (FRAME + 20) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
